// File: rtl/ata_pio_sched.sv
// rtl/ata_pio_sched.sv - ATA PIO bus-cycle scheduler with programmable timing mode
//
// Purpose: translates CPU address-strobe cycles in the IDE task-file window into
// ATA PIO chip-select / read / write strobes with mode-dependent setup, active
// and recovery times, honours IORDY (WAIT) stretching with a timeout, and
// provides a small config window holding the PIO mode.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RESET    in   asynchronous active-low reset
//   AS       in   CPU address strobe, active-low
//   RW       in   1 = read, 0 = write
//   A[31:0]  in   CPU address
//   D[7:0]   in   CPU data, D[1:0] = PIO mode on config writes
//   WAIT     in   drive IORDY, low stretches the active strobe
//   IDECS    out  active-low chip selects {CS1,CS0}
//   IOR/IOW  out  active-low drive read/write strobes
//   DTACK    out  active-low cycle acknowledge
//   ACCESS   out  active-low, combinational window decode of A
//   TIMEOUT  out  sticky WAIT-timeout flag
module ata_pio_sched #(
    parameter logic [16:0] IDE_BASE = 17'h1B4,
    parameter logic [16:0] CFG_BASE = 17'h1B5,
    parameter logic [7:0]  TO_LIMIT = 8'd255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        AS,
    input  logic        RW,
    input  logic [31:0] A,
    input  logic [7:0]  D,
    input  logic        WAIT,
    output logic [1:0]  IDECS,
    output logic        IOR,
    output logic        IOW,
    output logic        DTACK,
    output logic        ACCESS,
    output logic        TIMEOUT
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_HOLD    = 3'd3,
        S_ACK     = 3'd4,
        S_RECOVER = 3'd5,
        S_CFGACK  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        rw_q, rw_d;
    logic [1:0]  idecs_q, idecs_d;
    logic        ior_q, ior_d;
    logic        iow_q, iow_d;
    logic        dtack_q, dtack_d;
    logic        timeout_q, timeout_d;

    logic        ide_hit;
    logic        cfg_hit;
    logic        wait_expired;
    logic        unused_bits;

    assign ide_hit = (A[31:15] == IDE_BASE);
    assign cfg_hit = (A[31:15] == CFG_BASE);
    assign ACCESS  = ~(ide_hit | cfg_hit);

    // Only A[12] (CS select) and D[1:0] (mode) carry meaning below the window.
    assign unused_bits = ^{A[14:13], A[11:0], D[7:2]};

    // Widened compare so a limit of 255 does not wrap the 8-bit counter.
    assign wait_expired = ({1'b0, wcnt_q} + 9'd1) >= {1'b0, TO_LIMIT};

    function automatic logic [7:0] t1_of(input logic [1:0] m);
        case (m)
            2'd0:    t1_of = 8'd2;
            2'd1:    t1_of = 8'd2;
            2'd2:    t1_of = 8'd1;
            default: t1_of = 8'd1;
        endcase
    endfunction

    function automatic logic [7:0] t2_of(input logic [1:0] m);
        case (m)
            2'd0:    t2_of = 8'd7;
            2'd1:    t2_of = 8'd5;
            2'd2:    t2_of = 8'd4;
            default: t2_of = 8'd2;
        endcase
    endfunction

    function automatic logic [7:0] tr_of(input logic [1:0] m);
        case (m)
            2'd0:    tr_of = 8'd6;
            2'd1:    tr_of = 8'd4;
            2'd2:    tr_of = 8'd2;
            default: tr_of = 8'd1;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            cnt_q     <= 8'd0;
            wcnt_q    <= 8'd0;
            rw_q      <= 1'b1;
            idecs_q   <= 2'b11;
            ior_q     <= 1'b1;
            iow_q     <= 1'b1;
            dtack_q   <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            rw_q      <= rw_d;
            idecs_q   <= idecs_d;
            ior_q     <= ior_d;
            iow_q     <= iow_d;
            dtack_q   <= dtack_d;
            timeout_q <= timeout_d;
        end
    end

    // Counter phases end on the cycle the count is 1 (or 0), so a phase
    // loaded with N lasts exactly N cycles.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        rw_d      = rw_q;
        idecs_d   = idecs_q;
        ior_d     = ior_q;
        iow_d     = iow_q;
        dtack_d   = dtack_q;
        timeout_d = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (!AS && ide_hit) begin
                    state_d = S_SETUP;
                    cnt_d   = t1_of(mode_q);
                    rw_d    = RW;
                    idecs_d = A[12] ? 2'b01 : 2'b10;
                end else if (!AS && cfg_hit && !RW) begin
                    state_d   = S_CFGACK;
                    mode_d    = D[1:0];
                    timeout_d = 1'b0;
                    dtack_d   = 1'b0;
                end
            end

            S_SETUP: begin
                if (AS) begin
                    state_d = S_RECOVER;
                    cnt_d   = tr_of(mode_q);
                    idecs_d = 2'b11;
                    dtack_d = 1'b1;
                end else if (cnt_q <= 8'd1) begin
                    state_d = S_STROBE;
                    cnt_d   = t2_of(mode_q);
                    wcnt_d  = 8'd0;
                    ior_d   = ~rw_q;
                    iow_d   = rw_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_STROBE: begin
                if (AS) begin
                    state_d = S_RECOVER;
                    cnt_d   = tr_of(mode_q);
                    wcnt_d  = 8'd0;
                    idecs_d = 2'b11;
                    ior_d   = 1'b1;
                    iow_d   = 1'b1;
                    dtack_d = 1'b1;
                end else if (WAIT) begin
                    wcnt_d = 8'd0;
                    if (cnt_q <= 8'd1) begin
                        state_d = S_HOLD;
                        cnt_d   = 8'd0;
                        ior_d   = 1'b1;
                        iow_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else if (wait_expired) begin
                    // Device never released IORDY: finish the cycle anyway.
                    state_d   = S_HOLD;
                    cnt_d     = 8'd0;
                    wcnt_d    = 8'd0;
                    ior_d     = 1'b1;
                    iow_d     = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end

            S_HOLD: begin
                if (AS) begin
                    state_d = S_RECOVER;
                    cnt_d   = tr_of(mode_q);
                    idecs_d = 2'b11;
                    dtack_d = 1'b1;
                end else begin
                    state_d = S_ACK;
                    dtack_d = 1'b0;
                end
            end

            S_ACK: begin
                if (AS) begin
                    state_d = S_RECOVER;
                    cnt_d   = tr_of(mode_q);
                    idecs_d = 2'b11;
                    dtack_d = 1'b1;
                end
            end

            S_RECOVER: begin
                if (cnt_q <= 8'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_CFGACK: begin
                if (AS) begin
                    state_d = S_IDLE;
                    dtack_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                wcnt_d  = 8'd0;
                idecs_d = 2'b11;
                ior_d   = 1'b1;
                iow_d   = 1'b1;
                dtack_d = 1'b1;
            end
        endcase
    end

    assign IDECS   = idecs_q;
    assign IOR     = ior_q;
    assign IOW     = iow_q;
    assign DTACK   = dtack_q;
    assign TIMEOUT = timeout_q;

endmodule
